// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: multi-cycle control sequencer for the 16-bit RISC core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH and drives
// the PC, register file, ALU and data-memory handshake strobes.
// Optional build macro: RISC_CTRL_MEM_TIMEOUT_EN adds a memory wait-cycle
// watchdog that halts the core after TIMEOUT_CYCLES stalled cycles.
module risc_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  output logic        pc_reset,
  output logic        loadpc,
  output logic        msel,
  output logic        addr_sel,
  output logic        mem_req,
  output logic        mem_write,
  output logic        load_ir,
  output logic        load_a,
  output logic        load_b,
  output logic        load_c,
  output logic        load_s,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic [2:0]  wr_addr,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  alu_op,
  output logic [1:0]  shift,
  output logic [1:0]  vsel,
  output logic        write,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        mem_timeout
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  state_t state_r;
  logic   halted_r;
  logic   illegal_r;
  logic   mem_timeout_r;

  // Instruction fields
  logic [2:0] opcode_s;
  logic [1:0] op_s;
  logic [2:0] rn_s;
  logic [2:0] rd_s;
  logic [1:0] sh_s;
  logic [2:0] rm_s;

  assign opcode_s = instr[15:13];
  assign op_s     = instr[12:11];
  assign rn_s     = instr[10:8];
  assign rd_s     = instr[7:5];
  assign sh_s     = instr[4:3];
  assign rm_s     = instr[2:0];

  // Instruction class decode
  logic is_movi_s, is_movr_s, is_alu_s, is_cmp_s, is_ldr_s, is_str_s, is_b_s, is_halt_s;
  logic is_legal_s;

  assign is_movi_s  = (opcode_s == 3'b110) && (op_s == 2'b10);
  assign is_movr_s  = (opcode_s == 3'b110) && (op_s == 2'b00);
  assign is_alu_s   = (opcode_s == 3'b101);
  assign is_cmp_s   = is_alu_s && (op_s == 2'b01);
  assign is_ldr_s   = (opcode_s == 3'b011);
  assign is_str_s   = (opcode_s == 3'b100);
  assign is_b_s     = (opcode_s == 3'b001);
  assign is_halt_s  = (opcode_s == 3'b111);
  assign is_legal_s = is_movi_s | is_movr_s | is_alu_s | is_ldr_s |
                      is_str_s | is_b_s | is_halt_s;

  // Memory wait watchdog: timeout_hit_s flags the last tolerated stall cycle
  logic timeout_hit_s;

`ifdef RISC_CTRL_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_r;
  logic       waiting_s;

  assign waiting_s     = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
  assign timeout_hit_s = waiting_s && (wait_cnt_r == 8'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled memory cycles; zero whenever not stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else if (waiting_s && !timeout_hit_s) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end
`else
  logic [7:0] unused_timeout_s;
  assign unused_timeout_s = 8'(TIMEOUT_CYCLES);
  assign timeout_hit_s    = 1'b0;
`endif

  // State sequencing plus the sticky halt/illegal/timeout flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RST;
      halted_r      <= 1'b0;
      illegal_r     <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RST: state_r <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state_r <= ST_DECODE;
          end else if (timeout_hit_s) begin
            state_r       <= ST_HALT;
            halted_r      <= 1'b1;
            mem_timeout_r <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (is_movi_s) begin
            state_r <= ST_WB;
          end else if (is_halt_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else if (!is_legal_s) begin
            state_r   <= ST_HALT;
            halted_r  <= 1'b1;
            illegal_r <= 1'b1;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_cmp_s) begin
            state_r <= ST_FETCH;
          end else if (is_ldr_s || is_str_s) begin
            state_r <= ST_MEM;
          end else if (is_b_s) begin
            state_r <= ST_BRANCH;
          end else begin
            state_r <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_r <= is_ldr_s ? ST_WB : ST_FETCH;
          end else if (timeout_hit_s) begin
            state_r       <= ST_HALT;
            halted_r      <= 1'b1;
            mem_timeout_r <= 1'b1;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB:     state_r <= ST_FETCH;
        ST_BRANCH: state_r <= ST_FETCH;
        ST_HALT:   state_r <= ST_HALT;
        default:   state_r <= ST_RST;
      endcase
    end
  end

  // Datapath strobes decoded from the current state and instruction
  always_comb begin
    pc_reset  = 1'b0;
    loadpc    = 1'b0;
    msel      = 1'b0;
    addr_sel  = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    load_ir   = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    load_s    = 1'b0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    wr_addr   = 3'd0;
    asel      = 1'b0;
    bsel      = 1'b0;
    alu_op    = 2'b00;
    shift     = 2'b00;
    vsel      = 2'b00;
    write     = 1'b0;
    case (state_r)
      ST_RST: pc_reset = 1'b1;
      ST_FETCH: begin
        mem_req = 1'b1;
        load_ir = mem_ready;
      end
      ST_DECODE: begin
        loadpc    = 1'b1;
        load_a    = 1'b1;
        load_b    = 1'b1;
        rd_addr_a = rn_s;
        rd_addr_b = is_str_s ? rd_s : rm_s;
      end
      ST_EXEC: begin
        load_c = !is_cmp_s;
        load_s = is_cmp_s;
        alu_op = is_alu_s ? op_s : 2'b00;
        shift  = (is_alu_s || is_movr_s) ? sh_s : 2'b00;
        bsel   = is_ldr_s | is_str_s | is_b_s;
        asel   = is_b_s;
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_write = is_str_s;
      end
      ST_WB: begin
        write   = 1'b1;
        wr_addr = is_movi_s ? rn_s : rd_s;
        vsel    = is_movi_s ? 2'b10 : (is_ldr_s ? 2'b01 : 2'b00);
      end
      ST_BRANCH: msel = 1'b1;
      ST_HALT:   pc_reset = 1'b0;
      default:   pc_reset = 1'b0;
    endcase
  end

  assign state       = state_r;
  assign halted      = halted_r;
  assign illegal     = illegal_r;
  assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed, table-driven bench for risc_ctrl_fsm (default build).
module tb_risc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic        pc_reset, loadpc, msel, addr_sel, mem_req, mem_write;
  logic        load_ir, load_a, load_b, load_c, load_s;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic        asel, bsel;
  logic [1:0]  alu_op, shift, vsel;
  logic        write;
  logic [2:0]  state;
  logic        halted, illegal, mem_timeout;

  risc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .pc_reset(pc_reset), .loadpc(loadpc), .msel(msel), .addr_sel(addr_sel),
    .mem_req(mem_req), .mem_write(mem_write), .load_ir(load_ir),
    .load_a(load_a), .load_b(load_b), .load_c(load_c), .load_s(load_s),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
    .asel(asel), .bsel(bsel), .alu_op(alu_op), .shift(shift), .vsel(vsel),
    .write(write), .state(state), .halted(halted), .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_reset, loadpc, msel, addr_sel, mem_req, mem_write;
    logic       load_ir, load_a, load_b, load_c, load_s;
    logic [2:0] ra, rb, wa;
    logic       asel, bsel;
    logic [1:0] alu_op, shift, vsel;
    logic       write, halted, illegal, mem_timeout;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        mr;
    logic [2:0]  st;
    outs_t       o;
  } vec_t;

  vec_t  vecs[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  outs_t e;

  function automatic outs_t sample();
    outs_t s;
    s.pc_reset = pc_reset; s.loadpc = loadpc; s.msel = msel; s.addr_sel = addr_sel;
    s.mem_req = mem_req; s.mem_write = mem_write; s.load_ir = load_ir;
    s.load_a = load_a; s.load_b = load_b; s.load_c = load_c; s.load_s = load_s;
    s.ra = rd_addr_a; s.rb = rd_addr_b; s.wa = wr_addr; s.asel = asel; s.bsel = bsel;
    s.alu_op = alu_op; s.shift = shift; s.vsel = vsel; s.write = write;
    s.halted = halted; s.illegal = illegal; s.mem_timeout = mem_timeout;
    return s;
  endfunction

  task automatic add(input logic r, input logic [15:0] i, input logic m,
                     input logic [2:0] st, input outs_t o);
    vec_t v;
    v.rst = r; v.instr = i; v.mr = m; v.st = st; v.o = o;
    vecs.push_back(v);
  endtask

  // Apply inputs just after the falling edge, then settle before checking
  task automatic step(input logic r, input logic [15:0] i, input logic m);
    @(negedge clk);
    reset = r; instr = i; mem_ready = m;
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st, input outs_t x);
    outs_t g;
    g = sample();
    n_tests++;
    if (state !== st) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", name, state, st);
    end
    n_tests++;
    if (g !== x) begin
      n_fail++;
      $display("FAIL %s outputs: got %h expected %h", name, g, x);
    end
    n_tests++;
    if (loadpc && msel) begin
      n_fail++;
      $display("FAIL %s loadpc_msel: got both 1 expected not both", name);
    end
  endtask

  // FETCH -> DECODE -> HALT, hold for n cycles, then reset clears the flags
  task automatic run_to_halt(input string name, input logic [15:0] i,
                             input logic exp_ill, input int n);
    outs_t x;
    step(1'b0, i, 1'b1);
    x = '0; x.mem_req = 1'b1; x.load_ir = 1'b1;
    check({name, "_fetch"}, 3'd1, x);
    step(1'b0, i, 1'b0);
    for (int k = 0; k < n; k++) begin
      step(1'b0, i, k[0]);
      x = '0; x.halted = 1'b1; x.illegal = exp_ill;
      check({name, "_halt"}, 3'd7, x);
    end
    step(1'b1, i, 1'b1);
    step(1'b0, i, 1'b1);
    x = '0; x.pc_reset = 1'b1;
    check({name, "_rst"}, 3'd0, x);
  endtask

  initial begin
    reset = 1'b1; instr = 16'h0000; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    e = '0; e.pc_reset = 1'b1;                 add(1'b1, 16'h0000, 1'b0, 3'd0, e);
    e = '0; e.pc_reset = 1'b1;                 add(1'b0, 16'h0000, 1'b0, 3'd0, e);
    // MOV-imm R0, #5
    e = '0; e.mem_req = 1'b1; e.load_ir = 1'b1; add(1'b0, 16'hD005, 1'b1, 3'd1, e);
    e = '0; e.loadpc = 1'b1; e.load_a = 1'b1; e.load_b = 1'b1; e.rb = 3'd5;
                                               add(1'b0, 16'hD005, 1'b0, 3'd2, e);
    e = '0; e.write = 1'b1; e.vsel = 2'b10;    add(1'b0, 16'hD005, 1'b1, 3'd5, e);
    // LDR Rd=2, Rn=1 with three stall cycles in MEM
    e = '0; e.mem_req = 1'b1; e.load_ir = 1'b1; add(1'b0, 16'h6140, 1'b1, 3'd1, e);
    e = '0; e.loadpc = 1'b1; e.load_a = 1'b1; e.load_b = 1'b1; e.ra = 3'd1;
                                               add(1'b0, 16'h6140, 1'b0, 3'd2, e);
    e = '0; e.load_c = 1'b1; e.bsel = 1'b1;    add(1'b0, 16'h6140, 1'b1, 3'd3, e);
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1;
    add(1'b0, 16'h6140, 1'b0, 3'd4, e);
    add(1'b0, 16'h6140, 1'b0, 3'd4, e);
    add(1'b0, 16'h6140, 1'b0, 3'd4, e);
    add(1'b0, 16'h6140, 1'b1, 3'd4, e);
    e = '0; e.write = 1'b1; e.vsel = 2'b01; e.wa = 3'd2;
                                               add(1'b0, 16'h6140, 1'b0, 3'd5, e);
    // B
    e = '0; e.mem_req = 1'b1; e.load_ir = 1'b1; add(1'b0, 16'h2005, 1'b1, 3'd1, e);
    e = '0; e.loadpc = 1'b1; e.load_a = 1'b1; e.load_b = 1'b1; e.rb = 3'd5;
                                               add(1'b0, 16'h2005, 1'b1, 3'd2, e);
    e = '0; e.load_c = 1'b1; e.asel = 1'b1; e.bsel = 1'b1;
                                               add(1'b0, 16'h2005, 1'b0, 3'd3, e);
    e = '0; e.msel = 1'b1;                     add(1'b0, 16'h2005, 1'b1, 3'd6, e);
    // ADD R4 = R3 + (R2 shifted by 01)
    e = '0; e.mem_req = 1'b1; e.load_ir = 1'b1; add(1'b0, 16'hA38A, 1'b1, 3'd1, e);
    e = '0; e.loadpc = 1'b1; e.load_a = 1'b1; e.load_b = 1'b1; e.ra = 3'd3; e.rb = 3'd2;
                                               add(1'b0, 16'hA38A, 1'b0, 3'd2, e);
    e = '0; e.load_c = 1'b1; e.shift = 2'b01;  add(1'b0, 16'hA38A, 1'b0, 3'd3, e);
    e = '0; e.write = 1'b1; e.wa = 3'd4;       add(1'b0, 16'hA38A, 1'b1, 3'd5, e);
    // CMP R2, R3 shifted by 10
    e = '0; e.mem_req = 1'b1; e.load_ir = 1'b1; add(1'b0, 16'hAA33, 1'b1, 3'd1, e);
    e = '0; e.loadpc = 1'b1; e.load_a = 1'b1; e.load_b = 1'b1; e.ra = 3'd2; e.rb = 3'd3;
                                               add(1'b0, 16'hAA33, 1'b0, 3'd2, e);
    e = '0; e.load_s = 1'b1; e.alu_op = 2'b01; e.shift = 2'b10;
                                               add(1'b0, 16'hAA33, 1'b0, 3'd3, e);
    // STR Rd=6 -> [Rn=5]
    e = '0; e.mem_req = 1'b1; e.load_ir = 1'b1; add(1'b0, 16'h85C1, 1'b1, 3'd1, e);
    e = '0; e.loadpc = 1'b1; e.load_a = 1'b1; e.load_b = 1'b1; e.ra = 3'd5; e.rb = 3'd6;
                                               add(1'b0, 16'h85C1, 1'b0, 3'd2, e);
    e = '0; e.load_c = 1'b1; e.bsel = 1'b1;    add(1'b0, 16'h85C1, 1'b0, 3'd3, e);
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_write = 1'b1;
                                               add(1'b0, 16'h85C1, 1'b1, 3'd4, e);
    // MOV-reg R7 = R4 shifted by 11
    e = '0; e.mem_req = 1'b1; e.load_ir = 1'b1; add(1'b0, 16'hC0FC, 1'b1, 3'd1, e);
    e = '0; e.loadpc = 1'b1; e.load_a = 1'b1; e.load_b = 1'b1; e.rb = 3'd4;
                                               add(1'b0, 16'hC0FC, 1'b0, 3'd2, e);
    e = '0; e.load_c = 1'b1; e.shift = 2'b11;  add(1'b0, 16'hC0FC, 1'b0, 3'd3, e);
    e = '0; e.write = 1'b1; e.wa = 3'd7;       add(1'b0, 16'hC0FC, 1'b0, 3'd5, e);
    // FETCH stalls while memory is not ready
    e = '0; e.mem_req = 1'b1;
    add(1'b0, 16'hC0FC, 1'b0, 3'd1, e);
    add(1'b0, 16'hC0FC, 1'b0, 3'd1, e);

    for (int v = 0; v < vecs.size(); v++) begin
      step(vecs[v].rst, vecs[v].instr, vecs[v].mr);
      check($sformatf("vec%0d", v), vecs[v].st, vecs[v].o);
    end

    // Illegal opcode 000, held 20 cycles; reset clears the sticky flags
    run_to_halt("illegal_op000", 16'h0123, 1'b1, 20);
    // HALT instruction: halted without illegal
    run_to_halt("halt_instr", 16'hE000, 1'b0, 3);
    // Opcode 110 with op=01 is not a defined instruction
    run_to_halt("illegal_mov01", 16'hC800, 1'b1, 2);

    // Reset in the middle of an STR memory wait
    step(1'b0, 16'h85C1, 1'b1);
    step(1'b0, 16'h85C1, 1'b0);
    step(1'b0, 16'h85C1, 1'b0);
    step(1'b0, 16'h85C1, 1'b0);
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_write = 1'b1;
    check("str_mem_wait", 3'd4, e);
    step(1'b1, 16'h85C1, 1'b0);
    step(1'b0, 16'h85C1, 1'b1);
    e = '0; e.pc_reset = 1'b1;
    check("str_reset_mid_mem", 3'd0, e);
    step(1'b0, 16'h85C1, 1'b0);
    e = '0; e.mem_req = 1'b1;
    check("refetch_after_reset", 3'd1, e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
